// File: rtl/uart_rx_param_if.sv
// Byte-side handshake and status bundle of uart_rx_param; master = receiver, slave = consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Mid-bit sampling UART receiver with valid/ready word output, held until accepted; words arriving while one is still held are dropped with an overrun pulse.
// Optional parity check enabled by UART_RX_PARITY_EN; rx_valid follows the last stop-bit sample through a one-cycle DONE state.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rx,
  uart_rx_param_if.master bus
);

  // One extra bit so the counter can actually hold CLKS_PER_BIT when it is a power of two.
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT);
  localparam logic [3:0]    C_LAST = 4'(DATA_BITS - 1);
  localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  generate
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_param: unsupported parameter set");
    end
  endgenerate

  logic                 r_sync1, r_sync2;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_bad;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_rxs;
  logic                 w_perr;

  assign w_rxs = r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_perr;
  logic w_par_bad;
  // Data XOR parity bit must equal 0 for even parity, 1 for odd.
  assign w_par_bad = ((^r_shift) ^ r_par_bit) != PARITY_ODD[0];
  assign w_perr    = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_bad      <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_cnt   <= CW'(1);
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            if (!w_rxs) begin
              r_state   <= S_DATA;
              r_cnt     <= CW'(1);
              r_bit_idx <= '0;
              r_bad     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_cnt   <= CW'(1);
            if (r_bit_idx == C_LAST) begin
              r_stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_state    <= S_PARITY;
`else
              r_state    <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == C_FULL) begin
            r_par_bit <= w_rxs;
            r_cnt     <= CW'(1);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == C_FULL) begin
            if (!w_rxs) begin
              r_bad <= 1'b1;
            end
            r_cnt <= CW'(1);
            if (r_stop_idx == C_LAST_STOP) begin
              r_state <= S_DONE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          if (r_bad) begin
            r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (w_par_bad) begin
            r_perr <= 1'b1;
`endif
          end else if (r_valid && !bus.rx_ready) begin
            r_ovr <= 1'b1;
          end else begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.parity_err = w_perr;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: frames are modelled per byte, expected events queued at send time.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int PO  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;

  uart_rx_param_if #(.DATA_BITS(DB)) bus ();

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WORD, EV_FERR, EV_OVR, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DB-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            m_pending = 1'b0;
  logic [DB-1:0] m_pend_data = '0;

  function automatic void expect_ev(ev_kind_t k, logic [DB-1:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_event(ev_kind_t k, logic [DB-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s data=%0h, expected no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_WORD && e.data !== d)) begin
        errors++;
        $display("FAIL event_order: got %s data=%0h, expected %s data=%0h",
                 k.name(), d, e.kind.name(), e.data);
      end
    end
  endfunction

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid && bus.rx_ready) check_event(EV_WORD, bus.rx_data);
      if (bus.frame_err)  check_event(EV_FERR, '0);
      if (bus.overrun)    check_event(EV_OVR, '0);
      if (bus.parity_err) check_event(EV_PERR, '0);
    end
  end

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    if (r && m_pending) begin
      expect_ev(EV_WORD, m_pend_data);
      m_pending = 1'b0;
    end
    bus.rx_ready = r;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input bit par_flip);
    bit par_bad;
    logic par_bit;
`ifdef UART_RX_PARITY_EN
    par_bad = par_flip;
`else
    par_bad = 1'b0;
`endif
    par_bit = (^d) ^ PO[0] ^ par_flip;
    if (!stop_ok)              expect_ev(EV_FERR, '0);
    else if (par_bad)          expect_ev(EV_PERR, '0);
    else if (m_pending)        expect_ev(EV_OVR, '0);
    else if (bus.rx_ready)     expect_ev(EV_WORD, d);
    else begin
      m_pending   = 1'b1;
      m_pend_data = d;
    end
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) uart_rx = 1'b1;
`endif
    for (int s = 0; s < SB; s++) drive_bit((s == SB - 1) ? stop_ok : 1'b1);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DB-1:0] d;
    bit            stop_ok;
    bit            flip;

    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_rx_valid",  32'(bus.rx_valid), 0);
    check_val("reset_rx_data",   32'(bus.rx_data), 0);
    check_val("reset_busy",      32'(bus.busy), 0);
    check_val("reset_flags",     32'({bus.frame_err, bus.overrun, bus.parity_err}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);

    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_val("glitch_busy",     32'(bus.busy), 0);
    check_val("glitch_rx_valid", 32'(bus.rx_valid), 0);

    send_frame(8'h3C, 1'b0, 1'b0);
    check_val("ferr_rx_valid",   32'(bus.rx_valid), 0);

    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    check_val("ovr_first_valid", 32'(bus.rx_valid), 1);
    check_val("ovr_first_data",  32'(bus.rx_data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    check_val("ovr_held_data",   32'(bus.rx_data), 32'h11);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check_val("ovr_drained",     32'(bus.rx_valid), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    check_val("perr_rx_valid",   32'(bus.rx_valid), 0);
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) set_ready(~bus.rx_ready);
      if (m_pending) check_val("rand_held_data", 32'(bus.rx_data), 32'(m_pend_data));
      d       = DB'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      flip    = ($urandom_range(0, 7) == 0);
`else
      flip    = 1'b0;
`endif
      send_frame(d, stop_ok, flip);
    end
    set_ready(1'b1);
    repeat (4) @(negedge clk);

    set_ready(1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check_val("midframe_busy",   32'(bus.busy), 1);
    rst_n     = 1'b0;
    uart_rx   = 1'b1;
    m_pending = 1'b0;
    @(negedge clk);
    check_val("rst_mid_rx_valid", 32'(bus.rx_valid), 0);
    check_val("rst_mid_rx_data",  32'(bus.rx_data), 0);
    check_val("rst_mid_busy",     32'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    set_ready(1'b1);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (20) @(negedge clk);

    check_val("queue_empty_at_end", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
